alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   Operand-issue stage directly upstream of the ALU (adc and siblings). Accepts decoded ALU ops,
//   gathers A from the accumulator and B from register file, immediate or (HL) bus byte, then
//   drives operand_A/operand_B/opcode stable for one full M-cycle (4 clk = 1 phi period).
//   Tracks T-state from phi so ALU inputs change only at M-cycle boundaries.
// PARAMETERS
//   DATA_WIDTH    8  operand width (gate_boy_pkg value)
//   OPCODE_WIDTH  4  ALU opcode width (gate_boy_pkg value)
//   SEL_WIDTH     3  source select: 0..5=B,C,D,E,H,L; 6=(HL) bus byte; 7=A
// PORTS
//   clk            in   1             4 MHz system clock, all logic on rising edge
//   rst            in   1             synchronous, active-low reset
//   phi            in   1             1 MHz M-cycle clock (2 clk high, 2 clk low)
//   instr_valid    in   1             decoded ALU op offered
//   instr_ready    out  1             stage can accept op this clk
//   instr_opcode   in   OPCODE_WIDTH  ALU opcode
//   instr_src_sel  in   SEL_WIDTH     B-operand source
//   instr_use_imm  in   1             B from immediate byte (overrides src_sel)
//   rf_rd_sel      out  SEL_WIDTH     regfile read select (combinational read)
//   rf_rd_data     in   DATA_WIDTH    regfile read data
//   acc_data       in   DATA_WIDTH    accumulator A
//   bus_req        out  1             request one byte from memory bus
//   bus_req_hl     out  1             1: address=HL, 0: address=PC (valid with bus_req)
//   bus_valid      in   1             bus byte present
//   bus_data       in   DATA_WIDTH    bus byte
//   operand_A      out  DATA_WIDTH    to ALU
//   operand_B      out  DATA_WIDTH    to ALU
//   opcode         out  OPCODE_WIDTH  to ALU
//   issue          out  1             1-clk pulse: new operands valid (T-state 0)
//   busy           out  1             op in flight (any state but IDLE)
// BEHAVIOUR
//   - Reset (rst==0 at clk edge): all outputs 0, state IDLE, aligned=0, decode/pending regs 0.
//     Mid-operation reset aborts the op; no issue pulse follows.
//   - phi_q <= phi; m_start = phi & ~phi_q. tstate (2b): 0 on m_start, else +1 mod 4.
//     aligned set on first m_start after reset; instr_ready=0 until aligned.
//   - Needs bus: use_imm | (src_sel==6). bus_req_hl = ~use_imm & (src_sel==6).
//   - FSM IDLE/WAIT_BUS/WAIT_M/ISSUE:
//     IDLE: instr_ready=aligned. Handshake (valid&ready) latches decode regs ->
//       WAIT_BUS if needs bus, else WAIT_M.
//     WAIT_BUS: bus_req=1; on bus_valid latch bus_data into imm_hold -> WAIT_M
//       (even if m_start same clk; issue then waits for following m_start).
//     WAIT_M: on m_start: operand_A<=acc_data; operand_B<=imm_hold if bus op, acc_data
//       if sel==7, else rf_rd_data; opcode<=decode opcode; -> ISSUE; issue=1 next clk.
//     ISSUE: outputs held 4 clk. instr_ready=1 while no pending op; handshake latches
//       pending regs. At next m_start: pending reg-source op -> issue directly (back-to-back,
//       one op per M-cycle); pending bus op -> WAIT_BUS; none -> IDLE.
//   - rf_rd_sel = decode sel (pending sel when promoting). operand_A/B/opcode change ONLY at
//     m_start edges; never mid M-cycle.
//   - Handshake and m_start same clk in IDLE: op accepted, waits for next m_start (no issue
//     same edge). bus_valid outside WAIT_BUS ignored.
// TESTING
//   1 Reset, phi running, instr_valid=1 before first phi rise -> instr_ready=0; ready=1 after it.
//   2 acc=0x01, B=0x01 (sel 0), opcode 0 -> at next m_start A=0x01,B=0x01, issue 1 clk, hold 4 clk.
//   3 use_imm, bus_valid 2 clk late with 0x3C -> bus_req until then, bus_req_hl=0; B=0x3C at m_start.
//   4 sel=6, bus 0x80; next op sel=7 (acc 0x55) accepted during ISSUE -> B=0x80 then B=0x55, no gap.
//   5 rst low in WAIT_BUS -> all outputs 0, busy=0, no issue; fresh op completes normally.
//   6 Random ops/delays vs model -> operands only change when tstate==0.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage_if
// Description : Decoded-op handshake, register-file read, memory-bus byte
//               fetch and ALU operand bundle for the ALU operand stage.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int SEL_WIDTH    = 3
);
    logic                    instr_valid;
    logic                    instr_ready;
    logic [OPCODE_WIDTH-1:0] instr_opcode;
    logic [SEL_WIDTH-1:0]    instr_src_sel;
    logic                    instr_use_imm;
    logic [SEL_WIDTH-1:0]    rf_rd_sel;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic [DATA_WIDTH-1:0]   acc_data;
    logic                    bus_req;
    logic                    bus_req_hl;
    logic                    bus_valid;
    logic [DATA_WIDTH-1:0]   bus_data;
    logic [DATA_WIDTH-1:0]   operand_A;
    logic [DATA_WIDTH-1:0]   operand_B;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    issue;
    logic                    busy;

    // Upstream decoder, register file, memory bus and ALU side
    modport master (
        output instr_valid, instr_opcode, instr_src_sel, instr_use_imm,
        output rf_rd_data, acc_data, bus_valid, bus_data,
        input  instr_ready, rf_rd_sel, bus_req, bus_req_hl,
        input  operand_A, operand_B, opcode, issue, busy
    );

    // Operand stage side
    modport slave (
        input  instr_valid, instr_opcode, instr_src_sel, instr_use_imm,
        input  rf_rd_data, acc_data, bus_valid, bus_data,
        output instr_ready, rf_rd_sel, bus_req, bus_req_hl,
        output operand_A, operand_B, opcode, issue, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand-issue stage ahead of the ALU. Accepts decoded ops,
//               gathers A (accumulator) and B (register, immediate or (HL)
//               byte) and presents them stable for a whole M-cycle, changing
//               only on the clk edge that sees phi rise (T-state 0).
// Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int SEL_WIDTH    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          phi,
    alu_operand_stage_if.slave bus_if
);
    localparam logic [SEL_WIDTH-1:0] SEL_HL = SEL_WIDTH'(6);
    localparam logic [SEL_WIDTH-1:0] SEL_A  = SEL_WIDTH'(7);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_BUS = 2'd1,
        S_WAIT_M   = 2'd2,
        S_ISSUE    = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    phi_q;
    logic                    aligned_q;
    logic [OPCODE_WIDTH-1:0] dec_opc_q;
    logic [SEL_WIDTH-1:0]    dec_sel_q;
    logic                    dec_imm_q;
    logic                    pend_valid_q;
    logic [OPCODE_WIDTH-1:0] pend_opc_q;
    logic [SEL_WIDTH-1:0]    pend_sel_q;
    logic                    pend_imm_q;
    logic [DATA_WIDTH-1:0]   imm_hold_q;
    logic [DATA_WIDTH-1:0]   op_a_q;
    logic [DATA_WIDTH-1:0]   op_b_q;
    logic [OPCODE_WIDTH-1:0] opc_q;
    logic                    issue_q;

    // phi rising edge seen on this clk edge: the edge that starts T-state 0
    logic m_start;
    assign m_start = phi & ~phi_q;

    logic in_bus, dec_bus, pend_bus, handshake;
    assign in_bus   = bus_if.instr_use_imm | (bus_if.instr_src_sel == SEL_HL);
    assign dec_bus  = dec_imm_q | (dec_sel_q == SEL_HL);
    assign pend_bus = pend_imm_q | (pend_sel_q == SEL_HL);

    // Ready only once M-cycle aligned; in ISSUE a single op may queue behind
    always_comb begin
        bus_if.instr_ready = 1'b0;
        case (state_q)
            S_IDLE:  bus_if.instr_ready = aligned_q;
            S_ISSUE: bus_if.instr_ready = ~pend_valid_q;
            default: bus_if.instr_ready = 1'b0;
        endcase
    end

    assign handshake = bus_if.instr_valid & bus_if.instr_ready;

    // The register read tracks whichever op issues next, so a queued op
    // promoted straight out of ISSUE reads its own source register.
    assign bus_if.rf_rd_sel = ((state_q == S_ISSUE) && pend_valid_q) ? pend_sel_q : dec_sel_q;

    // Non-bus B source: sel 7 is the accumulator, otherwise the register file
    logic [DATA_WIDTH-1:0] b_src;
    assign b_src = (bus_if.rf_rd_sel == SEL_A) ? bus_if.acc_data : bus_if.rf_rd_data;

    assign bus_if.bus_req    = (state_q == S_WAIT_BUS);
    assign bus_if.bus_req_hl = bus_if.bus_req & ~dec_imm_q & (dec_sel_q == SEL_HL);
    assign bus_if.busy       = (state_q != S_IDLE);
    assign bus_if.operand_A  = op_a_q;
    assign bus_if.operand_B  = op_b_q;
    assign bus_if.opcode     = opc_q;
    assign bus_if.issue      = issue_q;

    // phi sampler keeps running through reset so the first edge after reset
    // cannot be mistaken for a phi rise
    always_ff @(posedge clk) begin
        phi_q <= phi;
    end

    // Issue FSM: accept, fetch bus byte, wait for M-cycle start, hold operands
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            aligned_q    <= 1'b0;
            dec_opc_q    <= '0;
            dec_sel_q    <= '0;
            dec_imm_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_opc_q   <= '0;
            pend_sel_q   <= '0;
            pend_imm_q   <= 1'b0;
            imm_hold_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            opc_q        <= '0;
            issue_q      <= 1'b0;
        end else begin
            issue_q <= 1'b0;
            if (m_start) begin
                aligned_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (handshake) begin
                        dec_opc_q <= bus_if.instr_opcode;
                        dec_sel_q <= bus_if.instr_src_sel;
                        dec_imm_q <= bus_if.instr_use_imm;
                        state_q   <= in_bus ? S_WAIT_BUS : S_WAIT_M;
                    end
                end
                S_WAIT_BUS: begin
                    if (bus_if.bus_valid) begin
                        imm_hold_q <= bus_if.bus_data;
                        state_q    <= S_WAIT_M;
                    end
                end
                S_WAIT_M: begin
                    if (m_start) begin
                        op_a_q  <= bus_if.acc_data;
                        op_b_q  <= dec_bus ? imm_hold_q : b_src;
                        opc_q   <= dec_opc_q;
                        issue_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_start) begin
                        if (pend_valid_q) begin
                            dec_opc_q    <= pend_opc_q;
                            dec_sel_q    <= pend_sel_q;
                            dec_imm_q    <= pend_imm_q;
                            pend_valid_q <= 1'b0;
                            if (pend_bus) begin
                                state_q <= S_WAIT_BUS;
                            end else begin
                                // back-to-back: next op issues on this same edge
                                op_a_q  <= bus_if.acc_data;
                                op_b_q  <= b_src;
                                opc_q   <= pend_opc_q;
                                issue_q <= 1'b1;
                            end
                        end else if (handshake) begin
                            // accepted on the boundary itself: waits for the next one
                            dec_opc_q <= bus_if.instr_opcode;
                            dec_sel_q <= bus_if.instr_src_sel;
                            dec_imm_q <= bus_if.instr_use_imm;
                            state_q   <= in_bus ? S_WAIT_BUS : S_WAIT_M;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (handshake) begin
                        pend_valid_q <= 1'b1;
                        pend_opc_q   <= bus_if.instr_opcode;
                        pend_sel_q   <= bus_if.instr_src_sel;
                        pend_imm_q   <= bus_if.instr_use_imm;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage: directed scenarios
//               followed by random traffic against a queue-based op model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;
    logic clk;
    logic rst;
    logic phi;

    alu_operand_stage_if #(.DATA_WIDTH(8), .OPCODE_WIDTH(4), .SEL_WIDTH(3)) ifc ();

    alu_operand_stage #(.DATA_WIDTH(8), .OPCODE_WIDTH(4), .SEL_WIDTH(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .phi    (phi),
        .bus_if (ifc.slave)
    );

    logic [7:0] rf [8];
    assign ifc.rf_rd_data = rf[ifc.rf_rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] opc;
        logic [2:0] sel;
        logic       imm;
        logic       has;
        logic [7:0] data;
    } op_t;

    op_t  q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;
    int   pc    = 0;
    logic prev_phi = 1'b0;
    logic last_medge = 1'b0;
    logic last_hs = 1'b0;
    logic [7:0] prev_a = 8'h0, prev_b = 8'h0;
    logic [3:0] prev_o = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic needs_bus(input op_t o);
        return o.imm | (o.sel == 3'd6);
    endfunction

    // One clk: capture pre-edge inputs, advance phi, update model, check
    task automatic cyc();
        logic       pre_phi, pre_rst, hs, bd, changed, found;
        logic [7:0] pre_acc, pre_bus, exp_b;
        op_t        o, h;
        pre_phi = phi;
        pre_rst = rst;
        hs      = ifc.instr_valid & ifc.instr_ready;
        bd      = ifc.bus_req & ifc.bus_valid;
        pre_acc = ifc.acc_data;
        pre_bus = ifc.bus_data;
        o.opc   = ifc.instr_opcode;
        o.sel   = ifc.instr_src_sel;
        o.imm   = ifc.instr_use_imm;
        o.has   = 1'b0;
        o.data  = 8'h0;
        @(posedge clk);
        #1;
        cyc_n++;
        last_medge = pre_phi & ~prev_phi;
        prev_phi   = pre_phi;
        last_hs    = hs & pre_rst;
        pc  = (pc + 1) % 4;
        phi = (pc < 2);
        if (!pre_rst) begin
            q.delete();
        end else begin
            if (bd) begin
                found = 1'b0;
                foreach (q[i]) begin
                    if (!found && needs_bus(q[i]) && !q[i].has) begin
                        q[i].has  = 1'b1;
                        q[i].data = pre_bus;
                        found = 1'b1;
                    end
                end
                chk("bus_data_unclaimed", {31'd0, found}, 32'd1);
            end
            if (hs) q.push_back(o);
            chk("issue_off_t0", {31'd0, ifc.issue & ~last_medge}, 32'd0);
            changed = (ifc.operand_A != prev_a) || (ifc.operand_B != prev_b) || (ifc.opcode != prev_o);
            chk("operands_off_t0", {31'd0, changed & ~last_medge}, 32'd0);
            if (ifc.issue) begin
                if (q.size() == 0) begin
                    chk("issue_without_op", 32'd1, 32'd0);
                end else begin
                    h = q.pop_front();
                    if (needs_bus(h)) begin
                        chk("issued_before_bus", {31'd0, h.has}, 32'd1);
                        exp_b = h.data;
                    end else if (h.sel == 3'd7) begin
                        exp_b = pre_acc;
                    end else begin
                        exp_b = rf[h.sel];
                    end
                    chk("operand_A", {24'd0, ifc.operand_A}, {24'd0, pre_acc});
                    chk("operand_B", {24'd0, ifc.operand_B}, {24'd0, exp_b});
                    chk("opcode", {28'd0, ifc.opcode}, {28'd0, h.opc});
                end
            end
            if (ifc.bus_req) begin
                found = 1'b0;
                foreach (q[i]) begin
                    if (!found && needs_bus(q[i]) && !q[i].has) begin
                        found = 1'b1;
                        chk("bus_req_hl", {31'd0, ifc.bus_req_hl}, {31'd0, ~q[i].imm});
                    end
                end
                chk("bus_req_without_op", {31'd0, found}, 32'd1);
            end
        end
        prev_a = ifc.operand_A;
        prev_b = ifc.operand_B;
        prev_o = ifc.opcode;
    endtask

    task automatic send(input logic [3:0] opc, input logic [2:0] sel, input logic imm);
        int n;
        ifc.instr_valid   = 1'b1;
        ifc.instr_opcode  = opc;
        ifc.instr_src_sel = sel;
        ifc.instr_use_imm = imm;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_hs && n < 20);
        ifc.instr_valid = 1'b0;
        if (!last_hs) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_issue(input int maxn, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!ifc.issue && n < maxn);
        if (!ifc.issue) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int maxn);
        int n;
        n = 0;
        while (ifc.busy && n < maxn) begin
            cyc();
            n++;
        end
        if (ifc.busy) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_A"},     {24'd0, ifc.operand_A}, 32'd0);
        chk({tag, "_B"},     {24'd0, ifc.operand_B}, 32'd0);
        chk({tag, "_opc"},   {28'd0, ifc.opcode}, 32'd0);
        chk({tag, "_issue"}, {31'd0, ifc.issue}, 32'd0);
        chk({tag, "_busy"},  {31'd0, ifc.busy}, 32'd0);
        chk({tag, "_breq"},  {31'd0, ifc.bus_req}, 32'd0);
        chk({tag, "_hl"},    {31'd0, ifc.bus_req_hl}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ifc.instr_ready}, 32'd0);
    endtask

    initial begin
        int   n, t_first;
        logic done;
        rst = 1'b0;
        phi = 1'b1;
        ifc.instr_valid   = 1'b0;
        ifc.instr_opcode  = 4'h0;
        ifc.instr_src_sel = 3'd0;
        ifc.instr_use_imm = 1'b0;
        ifc.acc_data      = 8'h01;
        ifc.bus_valid     = 1'b0;
        ifc.bus_data      = 8'h00;
        rf[0] = 8'h01; rf[1] = 8'h21; rf[2] = 8'h32; rf[3] = 8'h43;
        rf[4] = 8'h54; rf[5] = 8'h65; rf[6] = 8'h76; rf[7] = 8'h87;

        // Reset state, then ready held low until the first phi rise
        repeat (5) cyc();
        chk_zero("reset");
        ifc.instr_valid   = 1'b1;
        ifc.instr_opcode  = 4'h0;
        ifc.instr_src_sel = 3'd0;
        ifc.instr_use_imm = 1'b0;
        rst = 1'b1;
        chk("t1_ready_pre", {31'd0, ifc.instr_ready}, 32'd0);
        n = 0;
        do begin
            cyc();
            n++;
            if (!last_medge) chk("t1_ready_pre", {31'd0, ifc.instr_ready}, 32'd0);
        end while (!last_medge && n < 8);
        chk("t1_ready_post", {31'd0, ifc.instr_ready}, 32'd1);

        // Simple register op: issues at the next M-cycle start and holds 4 clk
        cyc();
        chk("t2_handshake", {31'd0, last_hs}, 32'd1);
        ifc.instr_valid = 1'b0;
        wait_issue(12, n);
        chk("t2_latency", n, 32'd3);
        chk("t2_A", {24'd0, ifc.operand_A}, 32'h01);
        chk("t2_B", {24'd0, ifc.operand_B}, 32'h01);
        repeat (3) begin
            cyc();
            chk("t2_hold_issue", {31'd0, ifc.issue}, 32'd0);
            chk("t2_hold_B", {24'd0, ifc.operand_B}, 32'h01);
            chk("t2_hold_busy", {31'd0, ifc.busy}, 32'd1);
        end
        cyc();
        chk("t2_idle", {31'd0, ifc.busy}, 32'd0);

        // Immediate op with a late bus byte
        send(4'h1, 3'd2, 1'b1);
        repeat (2) begin
            chk("t3_bus_req", {31'd0, ifc.bus_req}, 32'd1);
            chk("t3_bus_hl", {31'd0, ifc.bus_req_hl}, 32'd0);
            cyc();
        end
        ifc.bus_valid = 1'b1;
        ifc.bus_data  = 8'h3C;
        cyc();
        ifc.bus_valid = 1'b0;
        chk("t3_bus_req_drop", {31'd0, ifc.bus_req}, 32'd0);
        wait_issue(12, n);
        chk("t3_B", {24'd0, ifc.operand_B}, 32'h3C);
        chk("t3_opc", {28'd0, ifc.opcode}, 32'h1);
        wait_idle(12);

        // (HL) op then accumulator op queued during ISSUE, back-to-back
        ifc.acc_data = 8'h55;
        send(4'h2, 3'd6, 1'b0);
        chk("t4_bus_hl", {31'd0, ifc.bus_req_hl}, 32'd1);
        ifc.bus_valid = 1'b1;
        ifc.bus_data  = 8'h80;
        cyc();
        ifc.bus_valid = 1'b0;
        wait_issue(12, n);
        chk("t4_B_first", {24'd0, ifc.operand_B}, 32'h80);
        t_first = cyc_n;
        send(4'h3, 3'd7, 1'b0);
        wait_issue(12, n);
        chk("t4_B_second", {24'd0, ifc.operand_B}, 32'h55);
        chk("t4_opc_second", {28'd0, ifc.opcode}, 32'h3);
        chk("t4_gap", cyc_n - t_first, 32'd4);
        wait_idle(12);

        // Reset while waiting on the bus aborts the op
        send(4'h5, 3'd6, 1'b0);
        chk("t5_in_wait_bus", {31'd0, ifc.bus_req}, 32'd1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk_zero("t5_reset");
        repeat (6) begin
            cyc();
            chk("t5_no_issue", {31'd0, ifc.issue}, 32'd0);
        end
        send(4'h6, 3'd1, 1'b0);
        wait_issue(12, n);
        chk("t5_B", {24'd0, ifc.operand_B}, 32'h21);
        chk("t5_opc", {28'd0, ifc.opcode}, 32'h6);
        wait_idle(12);

        // Random traffic against the queue model
        for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
        for (int k = 0; k < 400; k++) begin
            ifc.acc_data = 8'($urandom);
            if (!ifc.instr_valid || last_hs) begin
                ifc.instr_valid   = ($urandom_range(0, 2) == 0);
                ifc.instr_opcode  = 4'($urandom);
                ifc.instr_src_sel = 3'($urandom);
                ifc.instr_use_imm = ($urandom_range(0, 3) == 0);
            end
            ifc.bus_valid = ($urandom_range(0, 2) == 0);
            ifc.bus_data  = 8'($urandom);
            cyc();
        end
        ifc.instr_valid = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            ifc.bus_valid = 1'b1;
            ifc.bus_data  = 8'($urandom);
            cyc();
            done = (q.size() == 0) && !ifc.busy;
        end
        chk("t6_drain", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
